// File: rtl/pc_ras_unit_pkg.sv
// Shared types for the fetch-stage program counter: next-PC selects, halt states, RAS sizing.
package pc_ras_unit_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    PC_SEQ = 3'd0,
    PC_BR  = 3'd1,
    PC_J   = 3'd2,
    PC_JR  = 3'd3,
    PC_JAL = 3'd4,
    PC_RET = 3'd5
  } pcsrc_t;

  typedef logic [0:0] pcstate_t;
  localparam pcstate_t RUN    = 1'b0;
  localparam pcstate_t HALTED = 1'b1;

  function automatic int ras_ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/pc_ras_unit_if.sv
// Fetch PC control/status bundle: control+hazard side is master, the PC unit is slave.
interface pc_ras_unit_if;
  import pc_ras_unit_pkg::*;

  logic        pc_en;
  logic        halt;
  logic [2:0]  pc_src;
  logic        branch_taken;
  logic [15:0] imm16;
  logic [25:0] imm26;
  word_t       regval;
  word_t       imemaddr;
  word_t       pc_plus4;
  logic        halted;
  logic        ras_hit;
  logic        ras_empty;
  logic        ras_full;

  modport master (
    output pc_en, halt, pc_src, branch_taken, imm16, imm26, regval,
    input  imemaddr, pc_plus4, halted, ras_hit, ras_empty, ras_full
  );

  modport slave (
    input  pc_en, halt, pc_src, branch_taken, imm16, imm26, regval,
    output imemaddr, pc_plus4, halted, ras_hit, ras_empty, ras_full
  );
endinterface

// File: rtl/pc_ras_unit_ras_stack.sv
// Circular return-address stack; a push when full silently overwrites the oldest entry.
module ras_stack
  import pc_ras_unit_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  push,
  input  logic  pop,
  input  word_t din,
  output word_t top,
  output logic  empty,
  output logic  full
);
  localparam int PW = ras_ptr_w(DEPTH);

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_m1;
  logic [PW:0]   cnt;
  word_t         mem [DEPTH];

  // ptr is the next free slot, so the top lives one below it
  assign ptr_m1 = ptr - PW'(1);
  assign top    = mem[ptr_m1];
  assign empty  = (cnt == '0);
  assign full   = (cnt == (PW+1)'(DEPTH));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      if (!full) cnt <= cnt + (PW+1)'(1);
    end else if (pop && !empty) begin
      ptr <= ptr_m1;
      cnt <= cnt - (PW+1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[ptr] <= din;
  end
endmodule

// File: rtl/pc_ras_unit.sv
// Fetch-stage PC: MIPS next-PC select, sticky halt, optional return-address stack
// (compile with PC_RAS_EN defined to build the stack).
module pc_ras_unit
  import pc_ras_unit_pkg::*;
#(
  parameter word_t PC_INIT   = 32'h0000_0000,
  parameter int    RAS_DEPTH = 8
) (
  input logic          CLK,
  input logic          nRST,
  pc_ras_unit_if.slave bus
);
  word_t    pc_q, pc_p4, br_off, jtarget, next_pc, ras_top;
  pcstate_t state_q;
  logic     run, advance, is_ret, ras_use;

  assign pc_p4   = pc_q + 32'd4;
  assign br_off  = {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
  assign jtarget = {pc_p4[31:28], bus.imm26, 2'b00};
  assign run     = (state_q == RUN);
  // halt wins over pc_src: no PC move and no stack traffic on the halting cycle
  assign advance = bus.pc_en && run && !bus.halt;
  assign is_ret  = (pcsrc_t'(bus.pc_src) == PC_RET);

`ifdef PC_RAS_EN
  logic ras_empty_w, ras_full_w;

  ras_stack #(.DEPTH(RAS_DEPTH)) u_ras (
    .CLK   (CLK),
    .nRST  (nRST),
    .push  (advance && (pcsrc_t'(bus.pc_src) == PC_JAL)),
    .pop   (advance && ras_use),
    .din   (pc_p4),
    .top   (ras_top),
    .empty (ras_empty_w),
    .full  (ras_full_w)
  );

  assign ras_use       = is_ret && !ras_empty_w;
  assign bus.ras_empty = ras_empty_w;
  assign bus.ras_full  = ras_full_w;
`else
  // no storage: occupancy is permanently zero and PC_RET behaves as PC_JR
  localparam int CW = ras_ptr_w(RAS_DEPTH) + 1;
  logic [CW-1:0] ras_cnt;

  assign ras_cnt       = '0;
  assign ras_top       = '0;
  assign ras_use       = 1'b0;
  assign bus.ras_empty = (ras_cnt == '0);
  assign bus.ras_full  = (ras_cnt == CW'(RAS_DEPTH));
`endif

  always_comb begin
    next_pc = pc_q;
    case (pcsrc_t'(bus.pc_src))
      PC_SEQ:         next_pc = pc_p4;
      PC_BR:          next_pc = bus.branch_taken ? pc_p4 + br_off : pc_p4;
      PC_J, PC_JAL:   next_pc = jtarget;
      PC_JR:          next_pc = bus.regval;
      PC_RET:         next_pc = ras_use ? ras_top : bus.regval;
      default:        next_pc = pc_q;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc_q    <= PC_INIT;
      state_q <= RUN;
    end else if (bus.pc_en && run) begin
      if (bus.halt) state_q <= HALTED;
      else          pc_q    <= next_pc;
    end
  end

  assign bus.imemaddr = pc_q;
  assign bus.pc_plus4 = pc_p4;
  assign bus.halted   = (state_q == HALTED);
  assign bus.ras_hit  = ras_use;
endmodule
